// File: rtl/score_overlay.sv
// score_overlay
// Bitmap overlay renderer for the score/banner window of the VGA frame.
// The scan coordinate is mapped into a W x H window. An external
// synchronous ROM with two banks (normal / special image) is addressed from
// that position, and a 1-bit pixel is produced in step with the ROM latency.
// A mode input and a small flash FSM choose which bank is displayed.
//
// Ports:
//   clk          pixel/system clock
//   rst_n        asynchronous active-low reset
//   col_addr_sig current scan column (11 bits)
//   row_addr_sig current scan row (11 bits)
//   levelup_sig  level-up event; only its rising edge is used
//   mode         0 off, 1 steady normal, 2 flash burst on level-up, 3 blink
//   rom_addr     bitmap ROM address (registered)
//   rom_bank     ROM bank select, 0 normal / 1 special (registered)
//   rom_data     ROM output bit, valid one clock after rom_addr/rom_bank
//   score_out_c  overlay pixel, 2 clocks after the coordinate is sampled
//   busy         high while a flash burst is in progress
module score_overlay #(
  parameter int X0           = 40,
  parameter int Y0           = 210,
  parameter int W            = 240,
  parameter int H            = 120,
  parameter int ADDR_W       = 15,
  parameter int BLINK_PERIOD = 12_500_000,
  parameter int NUM_FLASH    = 4,
  parameter int INVERT       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       col_addr_sig,
  input  logic [10:0]       row_addr_sig,
  input  logic              levelup_sig,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_bank,
  input  logic              rom_data,
  output logic              score_out_c,
  output logic              busy
);

  // Counter only has to hold 0..BLINK_PERIOD-1.
  localparam int CNT_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int FL_W  = $clog2(NUM_FLASH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_PERIOD - 1);
  localparam logic [FL_W-1:0]  FL_INIT  = FL_W'(NUM_FLASH);
  localparam logic             INV_BIT  = (INVERT != 0);

  // Window bounds at 12 bits so X0+W / Y0+H cannot wrap.
  localparam logic [11:0] X_LO = 12'(X0);
  localparam logic [11:0] X_HI = 12'(X0 + W);
  localparam logic [11:0] Y_LO = 12'(Y0);
  localparam logic [11:0] Y_HI = 12'(Y0 + H);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FL_ON  = 2'd1,
    FL_OFF = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              phase_reg, phase_next;
  logic [FL_W-1:0]   flash_reg, flash_next;
  logic              lvl_prev_reg;
  logic              v1_reg, v2_reg;

  logic [11:0]       col_ext, row_ext;
  logic              in_win;
  logic [ADDR_W-1:0] addr_calc;
  logic              rise;
  logic              run;
  logic              cnt_last;
  logic              bank_sel;

  assign col_ext = {1'b0, col_addr_sig};
  assign row_ext = {1'b0, row_addr_sig};
  assign in_win  = (col_ext >= X_LO) && (col_ext < X_HI) &&
                   (row_ext >= Y_LO) && (row_ext < Y_HI);

  // Linear address; computing directly at ADDR_W bits gives the same
  // truncated result as the full-width product.
  assign addr_calc = ADDR_W'(row_ext - Y_LO) * ADDR_W'(W) + ADDR_W'(col_ext - X_LO);

  assign rise     = levelup_sig & ~lvl_prev_reg;
  assign busy     = (state_reg != IDLE);
  assign run      = (mode == 2'd3) || busy;
  assign cnt_last = (cnt_reg == CNT_LAST);

  // Next-state and timebase logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    flash_next = flash_reg;

    if (run) begin
      if (cnt_last) begin
        cnt_next   = '0;
        phase_next = ~phase_reg;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end else begin
      cnt_next   = '0;
      phase_next = 1'b0;
    end

    if (mode != 2'd2) begin
      state_next = IDLE;
    end else if (rise) begin
      // A new rising edge (re)starts the burst from its first ON phase.
      state_next = FL_ON;
      cnt_next   = '0;
      phase_next = 1'b0;
      flash_next = FL_INIT;
    end else begin
      case (state_reg)
        FL_ON: begin
          if (cnt_last) begin
            flash_next = flash_reg - FL_W'(1);
            state_next = (flash_reg == FL_W'(1)) ? IDLE : FL_OFF;
          end
        end
        FL_OFF: begin
          if (cnt_last) state_next = FL_ON;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    bank_sel = 1'b0;
    case (mode)
      2'd2:    bank_sel = (state_reg == FL_ON);
      2'd3:    bank_sel = phase_reg;
      default: bank_sel = 1'b0;
    endcase
  end

  // State register and timebase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      phase_reg    <= 1'b0;
      flash_reg    <= '0;
      lvl_prev_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      phase_reg    <= phase_next;
      flash_reg    <= flash_next;
      lvl_prev_reg <= levelup_sig;
    end
  end

  // Pixel pipeline: address/bank (stage 1), ROM read (stage 2), pixel (stage 3).
  // The bank is latched alongside the address, so rom_data is always
  // paired with the bank it was read from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr    <= '0;
      rom_bank    <= 1'b0;
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      score_out_c <= 1'b0;
    end else begin
      if (in_win) begin
        rom_addr <= addr_calc;
        rom_bank <= bank_sel;
        v1_reg   <= 1'b1;
      end else begin
        rom_addr <= '0;
        rom_bank <= 1'b0;
        v1_reg   <= 1'b0;
      end
      v2_reg <= v1_reg;
      if (v2_reg && (mode != 2'd0)) begin
        score_out_c <= rom_data ^ INV_BIT;
      end else begin
        score_out_c <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_score_overlay.sv
// Testbench for score_overlay. Reference model works from window arithmetic
// and elapsed-cycle counts: burst bank = 1 for even BLINK_PERIOD-long slots
// since the burst began, burst length = (2*NUM_FLASH-1)*BLINK_PERIOD clocks,
// blink phase = (clocks running / BLINK_PERIOD) mod 2.
module tb_score_overlay;

  localparam int X0 = 40;
  localparam int Y0 = 210;
  localparam int W = 240;
  localparam int H = 120;
  localparam int ADDR_W = 15;
  localparam int BP = 4;
  localparam int NF = 2;
  localparam int INVERT = 1;
  localparam int BURST_LEN = (2 * NF - 1) * BP;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [10:0]       col;
  logic [10:0]       row;
  logic              lvl;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_bank;
  logic              rom_data = 1'b0;
  logic              score_out_c;
  logic              busy;

  int checks = 0;
  int failures = 0;

  score_overlay #(
    .X0(X0), .Y0(Y0), .W(W), .H(H), .ADDR_W(ADDR_W),
    .BLINK_PERIOD(BP), .NUM_FLASH(NF), .INVERT(INVERT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .col_addr_sig(col),
    .row_addr_sig(row),
    .levelup_sig(lvl),
    .mode(mode),
    .rom_addr(rom_addr),
    .rom_bank(rom_bank),
    .rom_data(rom_data),
    .score_out_c(score_out_c),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // External synchronous ROM.
  bit rom_mem [0:1][0:32767];
  always @(posedge clk) rom_data <= rom_mem[rom_bank][rom_addr];

  // Reference model state.
  bit m_prev;
  bit m_active;
  int m_t;
  int m_tb;
  bit h_win [0:1];
  bit h_bank [0:1];
  int h_addr [0:1];
  int exp_addr;
  bit exp_bank;
  bit exp_score;
  bit exp_busy;

  function automatic bit model_win(int c, int r);
    return (c >= X0) && (c < X0 + W) && (r >= Y0) && (r < Y0 + H);
  endfunction

  function automatic bit model_bank();
    if (mode == 2'd2) return m_active && (((m_t / BP) % 2) == 0);
    if (mode == 2'd3) return ((m_tb / BP) % 2) == 1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_active = 0; m_t = 0; m_tb = 0;
    for (int i = 0; i < 2; i++) begin
      h_win[i] = 0; h_bank[i] = 0; h_addr[i] = 0;
    end
    exp_addr = 0; exp_bank = 0; exp_score = 0; exp_busy = 0;
  endtask

  // Advance one clock with the current inputs; leaves expected values for
  // the state just after the edge, and returns 1 ns after that edge.
  task automatic step();
    bit win;
    bit rise;
    bit run;
    bit bsel;
    win = model_win(int'(col), int'(row));
    bsel = model_bank();
    exp_score = (h_win[1] && mode != 2'd0) ? (rom_mem[h_bank[1]][h_addr[1]] ^ 1'(INVERT)) : 1'b0;
    exp_addr = win ? (int'(row) - Y0) * W + (int'(col) - X0) : 0;
    exp_bank = win ? bsel : 1'b0;
    rise = lvl && !m_prev;
    run = (mode == 2'd3) || m_active;
    if (mode == 2'd2 && rise) m_tb = 0;
    else if (run) m_tb++;
    else m_tb = 0;
    if (mode != 2'd2) m_active = 0;
    else if (rise) begin
      m_active = 1; m_t = 0;
    end else if (m_active) begin
      m_t++;
      if (m_t >= BURST_LEN) m_active = 0;
    end
    m_prev = lvl;
    h_win[1] = h_win[0]; h_bank[1] = h_bank[0]; h_addr[1] = h_addr[0];
    h_win[0] = win; h_bank[0] = exp_bank; h_addr[0] = exp_addr;
    exp_busy = m_active;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; col = 0; row = 0; lvl = 0; mode = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rom_addr !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", rom_addr); end
    checks++;
    if (rom_bank !== 1'b0) begin failures++; $display("FAIL reset_bank got=%b exp=0", rom_bank); end
    checks++;
    if (score_out_c !== 1'b0) begin failures++; $display("FAIL reset_pix got=%b exp=0", score_out_c); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_window_scan();
    int ones;
    ones = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32768; a++) rom_mem[b][a] = 1'b0;
    mode = 2'd1; row = 11'd210;
    for (int c = 38; c <= 285; c++) begin
      col = 11'(c);
      step();
      if (score_out_c === 1'b1) ones++;
      checks++;
      if (rom_addr !== ADDR_W'(exp_addr)) begin failures++; $display("FAIL scan_addr col=%0d got=%0d exp=%0d", c, rom_addr, exp_addr); end
      checks++;
      if (rom_bank !== exp_bank) begin failures++; $display("FAIL scan_bank col=%0d got=%b exp=%b", c, rom_bank, exp_bank); end
      checks++;
      if (score_out_c !== exp_score) begin failures++; $display("FAIL scan_pix col=%0d got=%b exp=%b", c, score_out_c, exp_score); end
    end
    checks++;
    if (ones != W) begin failures++; $display("FAIL scan_count got=%0d exp=%0d", ones, W); end
    col = 0; row = 0;
    repeat (3) step();
    $display("test_window_scan done ones=%0d", ones);
  endtask

  task automatic test_corner();
    rom_mem[0][28799] = 1'b1;
    mode = 2'd1; col = 11'd279; row = 11'd329;
    step();
    checks++;
    if (rom_addr !== ADDR_W'(28799)) begin failures++; $display("FAIL corner_addr got=%0d exp=28799", rom_addr); end
    checks++;
    if (rom_bank !== 1'b0) begin failures++; $display("FAIL corner_bank got=%b exp=0", rom_bank); end
    col = 0; row = 0;
    step();
    step();
    checks++;
    if (score_out_c !== 1'b0) begin failures++; $display("FAIL corner_pix got=%b exp=0", score_out_c); end
    checks++;
    if (score_out_c !== exp_score) begin failures++; $display("FAIL corner_model got=%b exp=%b", score_out_c, exp_score); end
    $display("test_corner done addr=%0d", rom_addr);
  endtask

  task automatic test_flash_burst();
    int busy_cycles;
    busy_cycles = 0;
    mode = 2'd2; row = 11'd250; col = 11'd100;
    repeat (2) step();
    lvl = 1;
    step();
    if (busy === 1'b1) busy_cycles++;
    lvl = 0;
    for (int i = 0; i < 20; i++) begin
      col = 11'($urandom_range(40, 279));
      step();
      if (busy === 1'b1) busy_cycles++;
      checks++;
      if (busy !== exp_busy) begin failures++; $display("FAIL burst_busy i=%0d got=%b exp=%b", i, busy, exp_busy); end
      checks++;
      if (rom_bank !== exp_bank) begin failures++; $display("FAIL burst_bank i=%0d got=%b exp=%b", i, rom_bank, exp_bank); end
      checks++;
      if (score_out_c !== exp_score) begin failures++; $display("FAIL burst_pix i=%0d got=%b exp=%b", i, score_out_c, exp_score); end
    end
    checks++;
    if (busy_cycles != BURST_LEN) begin failures++; $display("FAIL burst_len got=%0d exp=%0d", busy_cycles, BURST_LEN); end
    $display("test_flash_burst done busy_cycles=%0d", busy_cycles);
  endtask

  task automatic test_restart_and_hold();
    int starts;
    bit prev_busy;
    mode = 2'd2; row = 11'd300; col = 11'd200;
    lvl = 1; step(); lvl = 0;
    repeat (5) step();
    lvl = 1; step(); lvl = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (busy !== exp_busy) begin failures++; $display("FAIL restart_busy i=%0d got=%b exp=%b", i, busy, exp_busy); end
      checks++;
      if (rom_bank !== exp_bank) begin failures++; $display("FAIL restart_bank i=%0d got=%b exp=%b", i, rom_bank, exp_bank); end
    end
    starts = 0; prev_busy = busy;
    lvl = 1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (busy === 1'b1 && !prev_busy) starts++;
      prev_busy = busy;
      checks++;
      if (busy !== exp_busy) begin failures++; $display("FAIL hold_busy i=%0d got=%b exp=%b", i, busy, exp_busy); end
    end
    lvl = 0;
    checks++;
    if (starts != 1) begin failures++; $display("FAIL hold_starts got=%0d exp=1", starts); end
    step();
    $display("test_restart_and_hold done starts=%0d", starts);
  endtask

  task automatic test_blink_and_off();
    mode = 2'd3; row = 11'd220; col = 11'd60;
    for (int i = 0; i < 20; i++) begin
      col = 11'($urandom_range(40, 279));
      step();
      checks++;
      if (rom_bank !== exp_bank) begin failures++; $display("FAIL blink_bank i=%0d got=%b exp=%b", i, rom_bank, exp_bank); end
      checks++;
      if (score_out_c !== exp_score) begin failures++; $display("FAIL blink_pix i=%0d got=%b exp=%b", i, score_out_c, exp_score); end
    end
    mode = 2'd0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (score_out_c !== 1'b0) begin failures++; $display("FAIL off_pix i=%0d got=%b exp=0", i, score_out_c); end
    end
    mode = 2'd3;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (rom_bank !== exp_bank) begin failures++; $display("FAIL reblink_bank i=%0d got=%b exp=%b", i, rom_bank, exp_bank); end
    end
    $display("test_blink_and_off done");
  endtask

  task automatic test_reset_mid_burst();
    mode = 2'd2; row = 11'd260; col = 11'd150;
    lvl = 1; step(); lvl = 0;
    step(); step();
    #2 rst_n = 0;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++;
    if (score_out_c !== 1'b0) begin failures++; $display("FAIL rstmid_pix got=%b exp=0", score_out_c); end
    checks++;
    if (rom_addr !== '0) begin failures++; $display("FAIL rstmid_addr got=%0d exp=0", rom_addr); end
    checks++;
    if (rom_bank !== 1'b0) begin failures++; $display("FAIL rstmid_bank got=%b exp=0", rom_bank); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL postrst_busy i=%0d got=%b exp=0", i, busy); end
      checks++;
      if (rom_bank !== exp_bank) begin failures++; $display("FAIL postrst_bank i=%0d got=%b exp=%b", i, rom_bank, exp_bank); end
    end
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_random();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32768; a++) rom_mem[b][a] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) lvl = ~lvl;
      col = 11'($urandom_range(30, 290));
      row = 11'($urandom_range(200, 340));
      step();
      checks++;
      if (rom_addr !== ADDR_W'(exp_addr)) begin failures++; $display("FAIL rnd_addr i=%0d got=%0d exp=%0d", i, rom_addr, exp_addr); end
      checks++;
      if (rom_bank !== exp_bank) begin failures++; $display("FAIL rnd_bank i=%0d got=%b exp=%b", i, rom_bank, exp_bank); end
      checks++;
      if (score_out_c !== exp_score) begin failures++; $display("FAIL rnd_pix i=%0d got=%b exp=%b", i, score_out_c, exp_score); end
      checks++;
      if (busy !== exp_busy) begin failures++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, busy, exp_busy); end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_window_scan();
    test_corner();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32768; a++) rom_mem[b][a] = 1'($urandom_range(0, 1));
    test_flash_burst();
    test_restart_and_hold();
    test_blink_and_off();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
